// File: rtl/random_seq_checker.sv
// random_seq_checker
// Sink-side checker for random_seq_gen streams. It regenerates the expected
// linear or pseudo-random word sequence locally and compares it with every
// valid beat received while running. It reports sticky error status,
// saturating beat and error counts, and the first mismatching beat.
//
// Handshake: i_valid alone qualifies i_data. There is no ready and no
// backpressure. A beat is consumed on every clock edge where i_valid=1 and
// the checker is in RUN. Beats in IDLE or DONE are dropped. A beat in the
// same cycle as a start edge is also dropped.
//
// State visibility: o_checking is high in RUN and o_done is high in DONE.
// Both low means IDLE.
module random_seq_checker #(
   parameter int                      OUTPUT_WIDTH      = 32,
   parameter int                      WORD_WIDTH        = 8,
   parameter int                      LINEAR_COUNT      = 0,
   parameter int                      COUNT_DOWN        = 0,
   parameter int                      FIRST_WORD_LINEAR = 1,
   parameter logic [OUTPUT_WIDTH-1:0] INIT_VALUE        = '0,
   parameter int                      NUM_CHECKS        = 0,
   parameter int                      COUNT_WIDTH       = 32
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_start,
   input  logic                    i_valid,
   input  logic [OUTPUT_WIDTH-1:0] i_data,
   output logic                    o_checking,
   output logic                    o_done,
   output logic                    o_pass,
   output logic                    o_error,
   output logic [COUNT_WIDTH-1:0]  o_error_count,
   output logic [COUNT_WIDTH-1:0]  o_beat_count,
   output logic [OUTPUT_WIDTH-1:0] o_first_err_data,
   output logic [OUTPUT_WIDTH-1:0] o_first_err_exp
);

   // The expected register covers OUTPUT_WIDTH rounded up to whole words.
   localparam int NUM_WORDS = (OUTPUT_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
   localparam int EXP_WIDTH = NUM_WORDS * WORD_WIDTH;
   localparam logic [EXP_WIDTH-1:0]   INIT_EXP = EXP_WIDTH'(INIT_VALUE);
   localparam logic [WORD_WIDTH-1:0]  W_ONE    = WORD_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;

   if ((WORD_WIDTH % 8) != 0 || WORD_WIDTH < 8 || WORD_WIDTH > OUTPUT_WIDTH) begin : g_bad_word_width
      $error("random_seq_checker: WORD_WIDTH must be a nonzero multiple of 8 and no wider than OUTPUT_WIDTH");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    start_q, start_d;
   logic [EXP_WIDTH-1:0]    exp_q, exp_d, exp_next;
   logic                    checking_q, checking_d;
   logic                    done_q, done_d;
   logic                    pass_q, pass_d;
   logic                    error_q, error_d;
   logic [COUNT_WIDTH-1:0]  error_count_q, error_count_d;
   logic [COUNT_WIDTH-1:0]  beat_count_q, beat_count_d;
   logic [OUTPUT_WIDTH-1:0] first_err_data_q, first_err_data_d;
   logic [OUTPUT_WIDTH-1:0] first_err_exp_q, first_err_exp_d;

   logic                    start_edge;
   logic                    mismatch;
   logic                    last_beat;
   logic [WORD_WIDTH-1:0]   w0;
   logic [WORD_WIDTH-1:0]   rot;
   logic [WORD_WIDTH-1:0]   word_v;

   function automatic logic [WORD_WIDTH-1:0] rotl(input logic [WORD_WIDTH-1:0] d, input int k);
      return (d << k) | (d >> (WORD_WIDTH - k));
   endfunction

   // Next expected value. Every word is derived from the current word 0.
   always_comb begin
      w0       = exp_q[WORD_WIDTH-1:0];
      exp_next = '0;
      rot      = '0;
      word_v   = '0;
      for (int ii = 0; ii < NUM_WORDS; ii++) begin
         if (ii == 0 && FIRST_WORD_LINEAR != 0) begin
            word_v = w0 + W_ONE;
         end else if (LINEAR_COUNT != 0) begin
            if (COUNT_DOWN != 0) word_v = w0 - WORD_WIDTH'(ii) + W_ONE;
            else                 word_v = w0 + WORD_WIDTH'(ii) + W_ONE;
         end else begin
            rot    = rotl(w0, (ii + 5) % WORD_WIDTH);
            word_v = {rot[WORD_WIDTH-1:1], rot[2] ^ rot[4] ^ rot[5] ^ rot[7]};
         end
         exp_next[ii*WORD_WIDTH +: WORD_WIDTH] = word_v;
      end
   end

   // Control, comparison and status updates. A start edge wins over a beat.
   always_comb begin
      start_edge = i_start & ~start_q;
      mismatch   = (i_data != exp_q[OUTPUT_WIDTH-1:0]);
      last_beat  = (NUM_CHECKS != 0) && ((64'(beat_count_q) + 64'd1) == 64'(NUM_CHECKS));

      state_d          = state_q;
      start_d          = i_start;
      exp_d            = exp_q;
      checking_d       = checking_q;
      done_d           = done_q;
      pass_d           = pass_q;
      error_d          = error_q;
      error_count_d    = error_count_q;
      beat_count_d     = beat_count_q;
      first_err_data_d = first_err_data_q;
      first_err_exp_d  = first_err_exp_q;

      if (start_edge) begin
         state_d          = S_RUN;
         exp_d            = INIT_EXP;
         checking_d       = 1'b1;
         done_d           = 1'b0;
         pass_d           = 1'b0;
         error_d          = 1'b0;
         error_count_d    = '0;
         beat_count_d     = '0;
         first_err_data_d = '0;
         first_err_exp_d  = '0;
      end else if (state_q == S_RUN && i_valid) begin
         exp_d = exp_next;
         if (beat_count_q != CNT_MAX) beat_count_d = beat_count_q + CNT_ONE;
         if (mismatch) begin
            error_d = 1'b1;
            if (error_count_q != CNT_MAX) error_count_d = error_count_q + CNT_ONE;
            if (!error_q) begin
               first_err_data_d = i_data;
               first_err_exp_d  = exp_q[OUTPUT_WIDTH-1:0];
            end
         end
         if (last_beat) begin
            state_d    = S_DONE;
            checking_d = 1'b0;
            done_d     = 1'b1;
            pass_d     = ~error_d;
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q          <= S_IDLE;
         start_q          <= 1'b0;
         exp_q            <= INIT_EXP;
         checking_q       <= 1'b0;
         done_q           <= 1'b0;
         pass_q           <= 1'b0;
         error_q          <= 1'b0;
         error_count_q    <= '0;
         beat_count_q     <= '0;
         first_err_data_q <= '0;
         first_err_exp_q  <= '0;
      end else begin
         state_q          <= state_d;
         start_q          <= start_d;
         exp_q            <= exp_d;
         checking_q       <= checking_d;
         done_q           <= done_d;
         pass_q           <= pass_d;
         error_q          <= error_d;
         error_count_q    <= error_count_d;
         beat_count_q     <= beat_count_d;
         first_err_data_q <= first_err_data_d;
         first_err_exp_q  <= first_err_exp_d;
      end
   end

   assign o_checking       = checking_q;
   assign o_done           = done_q;
   assign o_pass           = pass_q;
   assign o_error          = error_q;
   assign o_error_count    = error_count_q;
   assign o_beat_count     = beat_count_q;
   assign o_first_err_data = first_err_data_q;
   assign o_first_err_exp  = first_err_exp_q;

endmodule
